// File: rtl/and_tree_scoreboard_pkg.sv
// rtl/and_tree_scoreboard_pkg.sv - shared FSM encodings and compare helper for the tree scoreboards
package and_tree_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2
    } state_t;

    // An unknown on either operand must never count as agreement.
    function automatic logic is_match(input logic a, input logic b);
        return ((a ^ b) === 1'b0);
    endfunction

endpackage

// File: rtl/and_tree_scoreboard_if.sv
// rtl/and_tree_scoreboard_if.sv - stimulus/observation bundle between the cosim regs and the scoreboard
interface and_tree_scoreboard_if #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 16,
    parameter int LAT_W = 8
);
    logic [N_IN-1:0]  in_vec;
    logic             z;
    logic             busy;
    logic             pass_pulse;
    logic             fail_pulse;
    logic             glitch;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [LAT_W-1:0] last_lat;
    logic [LAT_W-1:0] max_lat;

    modport master (
        output in_vec, z,
        input  busy, pass_pulse, fail_pulse, glitch,
        input  pass_count, fail_count, last_lat, max_lat
    );

    modport slave (
        input  in_vec, z,
        output busy, pass_pulse, fail_pulse, glitch,
        output pass_count, fail_count, last_lat, max_lat
    );
endinterface

// File: rtl/and_tree_scoreboard_sat_counter.sv
// rtl/and_tree_scoreboard_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/and_tree_scoreboard.sv
// rtl/and_tree_scoreboard.sv - checks z against &in_vec, measuring settle latency and flagging timeouts/glitches
module and_tree_scoreboard
    import and_tree_scoreboard_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int TIMEOUT    = 64,
    parameter int STABLE_CYC = 2,
    parameter int CNT_W      = 16,
    parameter int LAT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    and_tree_scoreboard_if.slave  bus
);
    localparam int STAB_W = $clog2(STABLE_CYC + 1);

    state_t            state;
    logic              primed;
    logic [N_IN-1:0]   prev_in;
    logic              exp_z;
    logic [LAT_W-1:0]  timer;
    logic [LAT_W-1:0]  match_lat;
    logic [STAB_W-1:0] stab;

    logic              chg;
    logic              match;
    logic              timed_out;
    logic              pass_now;
    logic              fail_now;
    logic [LAT_W-1:0]  pass_lat;
    logic [LAT_W-1:0]  timer_inc;

    // !== so that an unknown bit on in_vec is treated as a change.
    assign chg       = primed && ((bus.in_vec ^ prev_in) !== '0);
    assign match     = is_match(bus.z, exp_z);
    assign timed_out = (timer >= LAT_W'(TIMEOUT - 1));
    assign timer_inc = (timer == {LAT_W{1'b1}}) ? timer : timer + 1'b1;

    always_comb begin
        pass_now = 1'b0;
        fail_now = 1'b0;
        pass_lat = match_lat;
        case (state)
            ST_IDLE: begin
                fail_now = primed && !chg && !match;
            end
            ST_WAIT: begin
                pass_lat = timer;
                if (match) pass_now = (STABLE_CYC == 1);
                else       fail_now = timed_out;
            end
            ST_STABLE: begin
                pass_now = match && (stab == STAB_W'(STABLE_CYC - 1));
                fail_now = !pass_now && timed_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            primed         <= 1'b0;
            prev_in        <= '0;
            exp_z          <= 1'b0;
            timer          <= '0;
            match_lat      <= '0;
            stab           <= '0;
            bus.busy       <= 1'b0;
            bus.pass_pulse <= 1'b0;
            bus.fail_pulse <= 1'b0;
            bus.glitch     <= 1'b0;
            bus.last_lat   <= '0;
            bus.max_lat    <= '0;
        end else begin
            primed         <= 1'b1;
            prev_in        <= bus.in_vec;
            bus.pass_pulse <= pass_now;
            bus.fail_pulse <= fail_now;
            if (pass_now) begin
                bus.last_lat <= pass_lat;
                if (pass_lat > bus.max_lat) bus.max_lat <= pass_lat;
            end
            if (state == ST_IDLE && fail_now) bus.glitch <= 1'b1;

            // A change restarts the check even if a decision was just issued.
            if (!primed || chg) begin
                exp_z    <= &bus.in_vec;
                timer    <= '0;
                stab     <= '0;
                state    <= ST_WAIT;
                bus.busy <= 1'b1;
            end else begin
                case (state)
                    ST_WAIT: begin
                        timer <= timer_inc;
                        if (pass_now || fail_now) begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else if (match) begin
                            match_lat <= timer;
                            stab      <= STAB_W'(1);
                            state     <= ST_STABLE;
                        end
                    end
                    ST_STABLE: begin
                        timer <= timer_inc;
                        if (pass_now || fail_now) begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else if (match) begin
                            stab <= stab + 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .clr (rst),
        .inc (pass_now),
        .q   (bus.pass_count)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .clr (rst),
        .inc (fail_now),
        .q   (bus.fail_count)
    );
endmodule

// File: tb/tb_and_tree_scoreboard.sv
// tb/tb_and_tree_scoreboard.sv - scoreboard-driven self-checking bench for and_tree_scoreboard
module tb_and_tree_scoreboard;
    localparam int N_IN = 4;
    localparam int TIMEOUT = 64;
    localparam int STABLE_CYC = 2;
    localparam int CNT_W = 4;
    localparam int LAT_W = 8;
    localparam int K_PASS = 1;
    localparam int K_FAIL = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int kind;
        int lat;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_pass = 0;
    int   exp_fail = 0;
    ev_t  exp_q[$];

    and_tree_scoreboard_if #(.N_IN(N_IN), .CNT_W(CNT_W), .LAT_W(LAT_W)) bus ();

    and_tree_scoreboard #(
        .N_IN(N_IN), .TIMEOUT(TIMEOUT), .STABLE_CYC(STABLE_CYC),
        .CNT_W(CNT_W), .LAT_W(LAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every decision pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.pass_pulse || bus.fail_pulse)) begin
            int kind;
            ev_t e;
            kind = (bus.fail_pulse ? K_FAIL : 0) + (bus.pass_pulse ? K_PASS : 0);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got kind=%0d at cycle %0d, required none", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                if (kind !== e.kind || cyc !== e.cyc ||
                    (e.kind == K_PASS && int'(bus.last_lat) !== e.lat)) begin
                    n_bad++;
                    $display("FAIL pulse: got kind=%0d cyc=%0d lat=%0d, required kind=%0d cyc=%0d lat=%0d",
                             kind, cyc, bus.last_lat, e.kind, e.cyc, e.lat);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int lat, input int at);
        ev_t e;
        e.kind = kind;
        e.lat = lat;
        e.cyc = at;
        exp_q.push_back(e);
        if (kind == K_PASS) exp_pass = (exp_pass < CNT_MAX) ? exp_pass + 1 : CNT_MAX;
        else                exp_fail = (exp_fail < CNT_MAX) ? exp_fail + 1 : CNT_MAX;
    endtask

    task automatic test_reset;
        int c0;
        rst = 1'b1;
        bus.in_vec = 4'b0000;
        bus.z = 1'b0;
        tick(3);
        n_cmp++;
        if ({bus.busy, bus.pass_pulse, bus.fail_pulse, bus.glitch} !== 4'b0 ||
            bus.pass_count !== '0 || bus.fail_count !== '0 || bus.last_lat !== '0 || bus.max_lat !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b pc=%0d fc=%0d ll=%0d ml=%0d, required all 0",
                     bus.busy, bus.pass_count, bus.fail_count, bus.last_lat, bus.max_lat);
        end
        rst = 1'b0;
        tick(1);
        c0 = cyc;
        push_ev(K_PASS, 0, c0 + STABLE_CYC);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_wait_busy: got %b, required 1", bus.busy);
        end
        tick(3);
        n_cmp++;
        if (int'(bus.pass_count) !== exp_pass || bus.last_lat !== 8'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_pass: got pc=%0d ll=%0d busy=%b, required pc=%0d ll=0 busy=0",
                     bus.pass_count, bus.last_lat, bus.busy, exp_pass);
        end
    endtask

    task automatic test_latency;
        int c0;
        bus.in_vec = 4'b1111;
        tick(1);
        c0 = cyc;
        push_ev(K_PASS, 5, c0 + 5 + STABLE_CYC);
        tick(5);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.fail_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_waiting: got busy=%b fail=%b, required busy=1 fail=0", bus.busy, bus.fail_pulse);
        end
        bus.z = 1'b1;
        tick(3);
        n_cmp++;
        if (int'(bus.pass_count) !== exp_pass || bus.last_lat !== 8'd5 || bus.max_lat !== 8'd5) begin
            n_bad++;
            $display("FAIL latency_result: got pc=%0d ll=%0d ml=%0d, required pc=%0d ll=5 ml=5",
                     bus.pass_count, bus.last_lat, bus.max_lat, exp_pass);
        end
    endtask

    task automatic test_timeout;
        int c0;
        bus.in_vec = 4'b0111;
        tick(1);
        c0 = cyc;
        push_ev(K_FAIL, 0, c0 + TIMEOUT);
        tick(TIMEOUT - 1);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.fail_count !== '0) begin
            n_bad++;
            $display("FAIL timeout_early: got busy=%b fc=%0d, required busy=1 fc=0", bus.busy, bus.fail_count);
        end
        tick(1);
        bus.z = 1'b0;
        tick(2);
        n_cmp++;
        if (int'(bus.fail_count) !== exp_fail || bus.busy !== 1'b0 || bus.glitch !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_result: got fc=%0d busy=%b glitch=%b, required fc=%0d busy=0 glitch=0",
                     bus.fail_count, bus.busy, bus.glitch, exp_fail);
        end
    endtask

    task automatic test_glitch;
        int c0;
        bus.in_vec = 4'b1111;
        bus.z = 1'b1;
        tick(1);
        c0 = cyc;
        push_ev(K_PASS, 0, c0 + 2);
        push_ev(K_FAIL, 0, c0 + 3);
        tick(2);
        bus.z = 1'b0;
        tick(1);
        bus.z = 1'b1;
        tick(3);
        n_cmp++;
        if (bus.glitch !== 1'b1 || int'(bus.fail_count) !== exp_fail || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch: got glitch=%b fc=%0d busy=%b, required glitch=1 fc=%0d busy=0",
                     bus.glitch, bus.fail_count, bus.busy, exp_fail);
        end
    endtask

    task automatic test_preempt;
        int c0;
        bus.in_vec = 4'b0000;
        bus.z = 1'b0;
        tick(1);
        push_ev(K_PASS, 0, cyc + 2);
        tick(3);
        bus.in_vec = 4'b1111;
        tick(2);
        bus.in_vec = 4'b1110;
        tick(1);
        c0 = cyc;
        push_ev(K_PASS, 0, c0 + 2);
        tick(4);
        n_cmp++;
        if (int'(bus.pass_count) !== exp_pass || bus.fail_count !== exp_fail[CNT_W-1:0] || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL preempt: got pc=%0d fc=%0d pending=%0d, required pc=%0d fc=%0d pending=0",
                     bus.pass_count, bus.fail_count, exp_q.size(), exp_pass, exp_fail);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        bus.in_vec = 4'b0000;
        tick(1);
        c0 = cyc;
        push_ev(K_PASS, 0, c0 + 2);
        push_ev(K_PASS, 0, c0 + 4);
        tick(1);
        bus.in_vec = 4'b1111;
        tick(1);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.pass_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL decision_with_change: got busy=%b pass=%b, required busy=1 pass=1", bus.busy, bus.pass_pulse);
        end
        bus.z = 1'b1;
        tick(4);
        n_cmp++;
        if (int'(bus.pass_count) !== exp_pass || bus.busy !== 1'b0 || bus.max_lat !== 8'd5 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back: got pc=%0d busy=%b ml=%0d pending=%0d, required pc=%0d busy=0 ml=5 pending=0",
                     bus.pass_count, bus.busy, bus.max_lat, exp_q.size(), exp_pass);
        end
    endtask

    task automatic test_reset_and_saturation;
        bus.in_vec = 4'b0000;
        tick(3);
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({bus.busy, bus.pass_pulse, bus.fail_pulse, bus.glitch} !== 4'b0 ||
            bus.pass_count !== '0 || bus.fail_count !== '0 || bus.last_lat !== '0 || bus.max_lat !== '0) begin
            n_bad++;
            $display("FAIL mid_wait_reset: got busy=%b gl=%b pc=%0d fc=%0d ll=%0d ml=%0d, required all 0",
                     bus.busy, bus.glitch, bus.pass_count, bus.fail_count, bus.last_lat, bus.max_lat);
        end
        exp_pass = 0;
        exp_fail = 0;
        rst = 1'b0;
        bus.z = 1'b0;
        tick(1);
        push_ev(K_PASS, 0, cyc + 2);
        tick(3);
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            bus.in_vec[0] = ~bus.in_vec[0];
            tick(1);
            push_ev(K_PASS, 0, cyc + 2);
            tick(3);
        end
        n_cmp++;
        if (bus.pass_count !== {CNT_W{1'b1}} || bus.fail_count !== '0 || bus.glitch !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL saturation: got pc=%0d fc=%0d glitch=%b pending=%0d, required pc=%0d fc=0 glitch=0 pending=0",
                     bus.pass_count, bus.fail_count, bus.glitch, exp_q.size(), CNT_MAX);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_timeout;
        test_glitch;
        test_preempt;
        test_back_to_back;
        test_reset_and_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
